// File: rtl/mem_xfer_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_xfer_pkg
// Brief   : Shared state encoding and default widths for mem_xfer_sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_xfer_pkg;

    localparam int c_ADDR_W  = 16;
    localparam int c_CNT_W   = 17;
    localparam int c_TIMEOUT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_xfer_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : mem_xfer_sequencer_if
// Brief   : Control/status bundle between the sequencer and its environment.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_xfer_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 17
) ();

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_add;
    logic [CNT_W-1:0]  word_cnt;
    logic              st_end;
    logic              enable;
    logic [ADDR_W-1:0] add;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [CNT_W-1:0]  xfer_cnt;
    logic [2:0]        state_tb;

    modport slave (
        input  start, abort, start_add, word_cnt, st_end,
        output enable, add, busy, done, err_timeout, xfer_cnt, state_tb
    );

    modport master (
        output start, abort, start_add, word_cnt, st_end,
        input  enable, add, busy, done, err_timeout, xfer_cnt, state_tb
    );

endinterface

`default_nettype wire

// File: rtl/mem_xfer_sequencer_watchdog.sv
//------------------------------------------------------------------------------
// Module  : xfer_watchdog
// Brief   : Stall counter; o_expired flags the TIMEOUT-1 count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xfer_watchdog #(
    parameter int TIMEOUT = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_run,
    output logic      o_expired
);

    localparam int c_W = $clog2(TIMEOUT);

    logic [c_W-1:0] r_cnt;

    assign o_expired = (r_cnt == c_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !o_expired) begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_xfer_sequencer.sv
//------------------------------------------------------------------------------
// Module  : mem_xfer_sequencer
// Brief   : Walks a read-address range, handshaking each word via st_end.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_xfer_sequencer
    import mem_xfer_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W,
    parameter int CNT_W   = c_CNT_W,
    parameter int TIMEOUT = c_TIMEOUT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_xfer_sequencer_if.slave xfer
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_add;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  r_xfer;
    logic              r_enable;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_accept;
    logic              w_word_done;
    logic              w_expired;

    assign w_accept    = xfer.start && (r_state == ST_IDLE || r_state == ST_ERR);
    assign w_word_done = (r_state == ST_WAIT) && xfer.st_end && !xfer.abort;

    xfer_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != ST_WAIT),
        .i_run     ((r_state == ST_WAIT) && !xfer.st_end),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (xfer.start) begin
                    w_next = (xfer.word_cnt == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: w_next = xfer.abort ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (xfer.abort) begin
                    w_next = ST_IDLE;
                end else if (xfer.st_end) begin
                    w_next = (r_rem == CNT_W'(1)) ? ST_DONE : ST_GAP;
                end else if (w_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_GAP:  w_next = xfer.abort ? ST_IDLE : ST_ISSUE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_add    <= '0;
            r_rem    <= '0;
            r_xfer   <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_enable <= (w_next == ST_ISSUE) || (w_next == ST_WAIT);
            r_busy   <= (w_next == ST_ISSUE) || (w_next == ST_WAIT) || (w_next == ST_GAP);
            r_done   <= (w_next == ST_DONE);
            r_err    <= (w_next == ST_ERR);
            if (w_accept) begin
                r_rem  <= xfer.word_cnt;
                r_xfer <= '0;
                if (xfer.word_cnt != '0) begin
                    r_add <= xfer.start_add;
                end
            end else if (w_word_done) begin
                r_xfer <= r_xfer + CNT_W'(1);
                r_rem  <= r_rem - CNT_W'(1);
                if (r_rem != CNT_W'(1)) begin
                    r_add <= r_add + ADDR_W'(1);
                end
            end
        end
    end

    assign xfer.enable      = r_enable;
    assign xfer.add         = r_add;
    assign xfer.busy        = r_busy;
    assign xfer.done        = r_done;
    assign xfer.err_timeout = r_err;
    assign xfer.xfer_cnt    = r_xfer;
    assign xfer.state_tb    = r_state;

endmodule

`default_nettype wire
